// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a one-frame valid/ready slot.
// Ports: clk, resetn (async low), rx in; data/valid/frame_err/parity_err/overrun out, ready in.
module uart_rx_cfg #(
  parameter int CLOCK      = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV_R = CLOCK / (BAUD * OVERSAMPLE);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int PW    = $clog2(DIV + 1);
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TMAX = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);
  localparam logic          SMAX = 1'(STOP_BITS - 1);
  localparam logic          ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t state;

  logic                 s1, s2, s3;
  logic                 fall;
  logic [PW-1:0]        pcnt;
  logic                 tick;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic                 scnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_r;
  logic                 perr_r;
  logic                 done;

  // s3 is the previous synchronised value for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

  // prescaler held at 0 in IDLE so every frame starts phase-aligned
  assign tick = (state != ST_IDLE) && (pcnt == PMAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt <= '0;
    end else if (state == ST_IDLE || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      scnt   <= 1'b0;
      shreg  <= '0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            tcnt  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tcnt == HALF) begin
              tcnt <= '0;
              if (s2) begin
                state <= ST_IDLE;
              end else begin
                state  <= ST_DATA;
                bcnt   <= '0;
                ferr_r <= 1'b0;
                perr_r <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tcnt == TMAX) begin
              tcnt  <= '0;
              shreg <= {s2, shreg[DATA_BITS-1:1]};
              if (bcnt == BMAX) begin
                state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                scnt  <= 1'b0;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_PAR: begin
          if (tick) begin
            if (tcnt == TMAX) begin
              tcnt   <= '0;
              perr_r <= ((^shreg) ^ s2) != ODD;
              state  <= ST_STOP;
              scnt   <= 1'b0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tcnt == TMAX) begin
              tcnt   <= '0;
              ferr_r <= ferr_r | ~s2;
              if (scnt == SMAX) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                scnt <= 1'b1;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // single-entry output slot; a frame arriving while it is full is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data       <= shreg;
          frame_err  <= ferr_r;
          parity_err <= perr_r;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLOCK, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate in bits per second.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; legal values are even and >= 4.
REQ-004 SHALL have parameter DATA_BITS, default 8, meaning payload width; legal range is 5..9.
REQ-005 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-006 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits; legal values are 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 SHALL have port data, output, DATA_BITS bits: received payload, LSB first on the line.
REQ-011 SHALL have port valid, output, 1 bit: data and the error flags hold a frame not yet consumed.
REQ-012 SHALL have port ready, input, 1 bit: consumer accepts the frame when valid && ready.
REQ-013 SHALL have port frame_err, output, 1 bit: the held frame had a low stop bit.
REQ-014 SHALL have port parity_err, output, 1 bit: the held frame failed parity; always 0 when PARITY = 0.
REQ-015 SHALL have port overrun, output, 1 bit: one-cycle pulse marking a dropped frame.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser whose flops reset to 1; all later logic SHALL use only the synchronised value.
REQ-017 A prescaler SHALL emit a one-cycle tick every DIV = CLOCK/(BAUD*OVERSAMPLE) cycles (integer division, minimum 1).
- The prescaler SHALL restart from 0 on every IDLE->START transition.
REQ-018 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: on a synchronised falling edge (previous 1, current 0) the FSM SHALL enter START and clear the tick count.
- A line held low SHALL NOT retrigger the FSM.
REQ-020 START: at tick OVERSAMPLE/2 the FSM SHALL sample the line.
- If the sample is 1 (glitch), return to IDLE with no output change.
- If the sample is 0, go to DATA.
REQ-021 DATA: the FSM SHALL sample every OVERSAMPLE ticks thereafter (mid-bit) and shift the sample in at the MSB side, so the first bit received ends up in data[0].
- After DATA_BITS samples, go to PARITY if PARITY != 0, else to STOP.
REQ-022 PARITY: the FSM SHALL take one sample.
- With odd parity, the XOR of the payload and the parity bit SHALL equal 1; with even parity it SHALL equal 0.
- A mismatch SHALL set the internal parity-error bit.
REQ-023 STOP: the FSM SHALL sample STOP_BITS bits, each OVERSAMPLE ticks apart.
- Any stop sample of 0 SHALL set the internal frame-error bit.
- The remaining stop bits SHALL still be sampled.
REQ-024 On the clock cycle after the final stop sample, the frame SHALL complete and the FSM SHALL return to IDLE.
REQ-025 At completion, if the slot is free (valid = 0, or valid && ready in that same cycle), the block SHALL:
- load data, frame_err and parity_err;
- set valid = 1.
REQ-026 At completion, if the slot is occupied (valid = 1 and ready = 0), the block SHALL:
- drop the new frame;
- pulse overrun for exactly 1 cycle;
- leave data, frame_err, parity_err and valid unchanged.
REQ-027 Once set, valid, data and both error flags SHALL remain stable until the cycle after valid && ready.
- valid SHALL then clear unless a completion loads a new frame in that same cycle.
REQ-028 A frame with frame_err or parity_err set SHALL still be delivered through the valid/ready handshake.
REQ-029 The tick counter SHALL be at least clog2(OVERSAMPLE) bits wide.
- The prescaler SHALL be at least clog2(DIV+1) bits wide.
- Neither counter SHALL wrap before its terminal count.

Reset
REQ-030 While resetn = 0, the block SHALL set: FSM = IDLE, all counters = 0, synchroniser flops = 1, data = 0, valid = 0, frame_err = 0, parity_err = 0, overrun = 0.
REQ-031 Assertion of resetn mid-frame SHALL abort the frame with no partial delivery.
- After release, reception SHALL restart only on a new falling edge.

Verification
REQ-032 The bench SHALL use CLOCK = 1600000, BAUD = 100000, OVERSAMPLE = 16, so DIV = 1 and one bit is 16 cycles.
REQ-033 Scenario 8N1: send byte 0xA5, ready = 1 -> valid pulses for 1 cycle with data = 0xA5, frame_err = 0, parity_err = 0.
REQ-034 Scenario 8E1: send 0x03 with parity bit 1 -> parity_err = 1 and data = 0x03; with parity bit 0 -> parity_err = 0.
REQ-035 Scenario bad stop bit: send 0x55 with the stop bit low -> frame_err = 1 and data = 0x55.
- The line then held low for 100 cycles -> no further frame.
REQ-036 Scenario glitch: rx low for 4 cycles then high -> FSM returns to IDLE and valid stays 0.
REQ-037 Scenario overrun: ready = 0, send 0x11 then 0x22 -> data stays 0x11, valid stays 1, overrun pulses once at the end of 0x22.
- Raising ready then -> valid clears on the next cycle.
REQ-038 Scenario reset mid-frame: assert resetn = 0 at bit 4 of 0x0F -> all outputs 0.
- After release, a subsequent 0x0F is received correctly.
